// File: rtl/free_list_arbiter_pkg.sv
// Shared types and helpers for the free-address list manager.
package free_list_arbiter_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   // Increment with explicit wrap so non-power-of-two depths work.
   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned modulus);
      return (v + 1 == modulus) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/free_list_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a registered priority pointer
// that moves past the winner only in cycles that produce a grant.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_next;
   logic          found;
   int unsigned   cand;

   always_comb begin
      gnt      = '0;
      ptr_next = ptr;
      found    = 1'b0;
      cand     = 0;
      if (en) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
               gnt[cand] = 1'b1;
               ptr_next  = PW'((cand + 1) % NUM_REQ);
               found     = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= ptr_next;
      end
   end

endmodule

// File: rtl/free_list_arbiter.sv
// Free-address list: self-initialising circular buffer of storage addresses
// with round-robin arbitrated allocate and release ports.
module free_list_arbiter
   import free_list_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned INIT_VAL   = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            i__alloc_req,
   output logic [NUM_REQ-1:0]            o__alloc_gnt,
   output logic [DATA_WIDTH-1:0]         o__alloc_addr,
   input  logic [NUM_REQ-1:0]            i__free_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i__free_addr,
   output logic [NUM_REQ-1:0]            o__free_ready,
   output logic [$clog2(DEPTH+1)-1:0]    o__free_count,
   output logic                          o__init_done,
   output logic                          o__error
);

   localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);
   localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);
   localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(DEPTH - 1);

   state_t                 state, state_next;
   logic [PTR_WIDTH-1:0]   init_ptr, head, tail;
   logic [CNT_WIDTH-1:0]   count;
   logic                   error;
   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic                   ready_st, alloc_en, free_en, alloc_fire, free_fire, overflow;
   logic [NUM_REQ-1:0]     alloc_gnt, free_gnt;
   logic [DATA_WIDTH-1:0]  rel_addr;

   // Release may use the slot freed by a same-cycle allocation; the reverse is
   // never true, so a released address is only allocatable from the next cycle.
   assign ready_st   = !reset && (state == READY);
   assign alloc_en   = ready_st && (count != '0);
   assign alloc_fire = |alloc_gnt;
   assign free_en    = ready_st && ((count != FULL) || alloc_fire);
   assign free_fire  = |free_gnt;
   assign overflow   = ready_st && (|i__free_valid) && (count == FULL) && !alloc_fire;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_alloc_arb (
      .clk   (clk),
      .reset (reset),
      .en    (alloc_en),
      .req   (i__alloc_req),
      .gnt   (alloc_gnt)
   );

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_free_arb (
      .clk   (clk),
      .reset (reset),
      .en    (free_en),
      .req   (i__free_valid),
      .gnt   (free_gnt)
   );

   always_comb begin
      rel_addr = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (free_gnt[k]) rel_addr = i__free_addr[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         INIT:    if (init_ptr == LAST) state_next = READY;
         READY:   state_next = READY;
         default: state_next = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= INIT;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         init_ptr <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         error    <= 1'b0;
      end else if (state == INIT) begin
         count    <= count + CNT_WIDTH'(1);
         init_ptr <= (init_ptr == LAST) ? '0 : init_ptr + PTR_WIDTH'(1);
      end else begin
         if (alloc_fire) head <= PTR_WIDTH'(wrap_inc(32'(head), DEPTH));
         if (free_fire)  tail <= PTR_WIDTH'(wrap_inc(32'(tail), DEPTH));
         if (alloc_fire && !free_fire)      count <= count - CNT_WIDTH'(1);
         else if (free_fire && !alloc_fire) count <= count + CNT_WIDTH'(1);
         if (overflow) error <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == INIT) begin
            mem[init_ptr] <= DATA_WIDTH'(INIT_VAL) + DATA_WIDTH'(init_ptr);
         end else if (free_fire) begin
            mem[tail] <= rel_addr;
         end
      end
   end

   assign o__alloc_gnt  = alloc_gnt;
   assign o__alloc_addr = alloc_fire ? mem[head] : '0;
   assign o__free_ready = free_gnt;
   assign o__free_count = ready_st ? count : '0;
   assign o__init_done  = ready_st;
   assign o__error      = ready_st && error;

endmodule
